io_tx_queue: RTL and testbench

- Sits between the cpu top-level memory pins and the RAM/UART hardware, on the I/O side of the byte bus.
- Captures every CPU byte write to the I/O window (mem_a[17:16]==2'b11) and queues it in a small FIFO.
- Drains the FIFO to the UART whenever io_buffer_full allows, and turns a write to 0x30004 into an ordered stop event.
- Drives cpu_hold, which the top level ANDs into rdy_in so the CPU freezes instead of losing output bytes.

---
 rtl/io_tx_queue_pkg.sv | 22 ++
 rtl/io_fifo_mem.sv | 33 +++
 rtl/io_tx_queue.sv | 126 ++++++++++++
 tb/tb_io_tx_queue.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_tx_queue_pkg.sv
// Shared constants and types for the I/O transmit queue: window decode,
// port offsets, FIFO entry layout and controller states.
package io_tx_queue_pkg;

  localparam logic [1:0] IO_WIN_SEL   = 2'b11;
  localparam logic [2:0] IO_PORT_DATA = 3'h0;
  localparam logic [2:0] IO_PORT_STOP = 3'h4;
  localparam int         ENTRY_W      = 9;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STOPPING = 2'd1,
    ST_HALTED   = 2'd2
  } state_t;

  // A stop entry always carries a zero data byte regardless of the bus value.
  function automatic logic [ENTRY_W-1:0] make_entry(input logic       is_stop,
                                                    input logic [7:0] data);
    return {is_stop, (is_stop ? 8'h00 : data)};
  endfunction

endpackage

// File: rtl/io_fifo_mem.sv
// DEPTH x ENTRY_W register array for the transmit queue, with a registered
// read port that clears on reset so the UART data bus starts at zero.
module io_fifo_mem
  import io_tx_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_ptr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_ptr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [ENTRY_W-1:0] r_rd_data;

  always_ff @(posedge clk_in) begin
    if (wr_en) r_mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)    r_rd_data <= '0;
    else if (rd_en) r_rd_data <= r_mem[rd_ptr];
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/io_tx_queue.sv
// Queues CPU byte writes to the I/O window and drains them to the UART,
// turning a write to the stop port into an ordered halt. Optional counters
// are enabled with IO_TX_QUEUE_STATS_EN.
module io_tx_queue
  import io_tx_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  input  logic        io_buffer_full,
  output logic [7:0]  uart_data,
  output logic        uart_wr,
  output logic        stop_req,
  output logic        cpu_hold,
  output logic        overflow,
  output logic        halted,
`ifdef IO_TX_QUEUE_STATS_EN
  output logic [31:0] tx_count,
  output logic [31:0] hold_cycles,
`endif
  output logic [1:0]  dbg_state
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] HOLD_LVL = (AW+1)'(DEPTH - 1);

  state_t             r_state, w_state_nxt;
  logic [AW:0]        r_count;
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic               r_uart_wr, r_overflow;
  logic [ENTRY_W-1:0] w_rd_data;
  logic               w_io_hit, w_push_byte, w_push_stop, w_io_rd;
  logic               w_push_req, w_full, w_push_ok, w_drop, w_pop, w_stop_fire;
  logic               w_unused_addr;

  assign w_io_hit    = (cpu_a[17:16] == IO_WIN_SEL);
  assign w_push_byte = w_io_hit & cpu_wr & (cpu_a[2] == IO_PORT_DATA[2]) & (cpu_dout != 8'h00);
  assign w_push_stop = w_io_hit & cpu_wr & (cpu_a[2] == IO_PORT_STOP[2]);
  assign w_io_rd     = w_io_hit & ~cpu_wr;
  assign w_unused_addr = ^{cpu_a[31:18], cpu_a[15:3], cpu_a[1:0]};

  assign w_push_req = w_push_byte | w_push_stop;
  assign w_full     = (r_count == FULL_LVL);
  assign w_push_ok  = (r_state == ST_RUN) & w_push_req & ~w_full;
  assign w_drop     = (r_state == ST_RUN) & w_push_req & w_full;

  // Drain handshake: io_buffer_full is the UART's not-ready; uart_wr is a
  // one-cycle write and the forced idle cycle after it hides the UART's
  // one-cycle lag in raising io_buffer_full.
  assign w_pop       = (r_count != '0) & ~io_buffer_full & ~r_uart_wr;
  assign w_stop_fire = r_uart_wr & w_rd_data[ENTRY_W-1];

  io_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .wr_en   (w_push_ok),
    .wr_ptr  (r_wr_ptr),
    .wr_data (make_entry(w_push_stop, cpu_dout)),
    .rd_en   (w_pop),
    .rd_ptr  (r_rd_ptr),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= ST_RUN;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_uart_wr  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_uart_wr <= w_pop;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:      if (w_push_ok && w_push_stop) w_state_nxt = ST_STOPPING;
      ST_STOPPING: if (w_stop_fire)              w_state_nxt = ST_HALTED;
      ST_HALTED:   w_state_nxt = ST_HALTED;
      default:     w_state_nxt = ST_RUN;
    endcase
  end

  assign uart_data = w_rd_data[7:0];
  assign uart_wr   = r_uart_wr;
  assign stop_req  = w_stop_fire;
  assign overflow  = r_overflow;
  assign halted    = (r_state == ST_HALTED);
  assign dbg_state = r_state;
  assign cpu_hold  = (r_count >= HOLD_LVL) | (w_io_rd & (r_count != '0)) |
                     halted | (r_state == ST_STOPPING);

`ifdef IO_TX_QUEUE_STATS_EN
  logic [31:0] r_tx_count, r_hold_cycles;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_tx_count    <= '0;
      r_hold_cycles <= '0;
    end else begin
      if (r_uart_wr && (r_tx_count != '1)) r_tx_count <= r_tx_count + 1'b1;
      if (cpu_hold && !halted && (r_hold_cycles != '1)) r_hold_cycles <= r_hold_cycles + 1'b1;
    end
  end

  assign tx_count    = r_tx_count;
  assign hold_cycles = r_hold_cycles;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_io_tx_queue.sv
// Directed bench for io_tx_queue: a cycle table for basic output plus
// hand-written sequences for backpressure, stop, read ordering and reset.
module tb_io_tx_queue;

  localparam logic [31:0] A_DATA = 32'h0003_0000;
  localparam logic [31:0] A_STOP = 32'h0003_0004;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic        io_buffer_full;
  logic [7:0]  uart_data;
  logic        uart_wr, stop_req, cpu_hold, overflow, halted;
  logic [1:0]  dbg_state;
`ifdef IO_TX_QUEUE_STATS_EN
  logic [31:0] tx_count, hold_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  io_tx_queue dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .cpu_a          (cpu_a),
    .cpu_dout       (cpu_dout),
    .cpu_wr         (cpu_wr),
    .io_buffer_full (io_buffer_full),
    .uart_data      (uart_data),
    .uart_wr        (uart_wr),
    .stop_req       (stop_req),
    .cpu_hold       (cpu_hold),
    .overflow       (overflow),
    .halted         (halted),
`ifdef IO_TX_QUEUE_STATS_EN
    .tx_count       (tx_count),
    .hold_cycles    (hold_cycles),
`endif
    .dbg_state      (dbg_state)
  );

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
    logic        wr;
    logic        full;
    logic        exp_wr;
    logic [7:0]  exp_data;
    logic        exp_stop;
    logic        exp_hold;
    logic        exp_ovf;
    logic        exp_halted;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic [31:0] a, input logic [7:0] d, input logic wr,
                              input logic exp_wr, input logic [7:0] exp_data,
                              input logic exp_hold);
    vec_t v;
    v.a = a; v.d = d; v.wr = wr; v.full = 1'b0;
    v.exp_wr = exp_wr; v.exp_data = exp_data; v.exp_stop = 1'b0;
    v.exp_hold = exp_hold; v.exp_ovf = 1'b0; v.exp_halted = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] a, input logic [7:0] d, input logic wr);
    cpu_a = a; cpu_dout = d; cpu_wr = wr;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(32'h0, 8'h00, 1'b0);
    io_buffer_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  // Scoreboarded drain: every uart_wr must match the head of exp_q.
  task automatic drain_check(input string name, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (uart_wr) begin
        if (exp_q.size() == 0) check({name, "_extra"}, {24'h0, uart_data}, 32'hFFFF_FFFF);
        else                   check({name, "_data"}, {24'h0, uart_data}, {24'h0, exp_q.pop_front()});
      end
    end
    check({name, "_left"}, exp_q.size(), 0);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(32'h0, 8'h00, 1'b0);
    io_buffer_full = 1'b0;
    do_reset();

    @(negedge clk);
    check("reset_ctl", {uart_wr, stop_req, cpu_hold, overflow, halted}, 5'b0);
    check("reset_data", {24'h0, uart_data}, 32'h0);
    step();

    // Three bytes out on alternating cycles, zero write ignored, out-of-window ignored.
    vecs[0]  = mk(A_DATA,       8'h41, 1, 0, 8'h00, 0);
    vecs[1]  = mk(A_DATA,       8'h42, 1, 0, 8'h00, 0);
    vecs[2]  = mk(A_DATA,       8'h43, 1, 1, 8'h41, 0);
    vecs[3]  = mk(32'h0,        8'h00, 0, 0, 8'h00, 0);
    vecs[4]  = mk(32'h0,        8'h00, 0, 1, 8'h42, 0);
    vecs[5]  = mk(32'h0,        8'h00, 0, 0, 8'h00, 0);
    vecs[6]  = mk(32'h0,        8'h00, 0, 1, 8'h43, 0);
    vecs[7]  = mk(32'h0,        8'h00, 0, 0, 8'h00, 0);
    vecs[8]  = mk(A_DATA,       8'h00, 0, 0, 8'h00, 0);
    vecs[9]  = mk(A_DATA,       8'h00, 1, 0, 8'h00, 0);
    vecs[10] = mk(32'h0,        8'h00, 0, 0, 8'h00, 0);
    vecs[11] = mk(32'h0,        8'h00, 0, 0, 8'h00, 0);
    vecs[12] = mk(A_DATA,       8'h00, 0, 0, 8'h00, 0);
    vecs[13] = mk(32'h0002_0000, 8'h99, 1, 0, 8'h00, 0);
    vecs[14] = mk(32'h0,        8'h00, 0, 0, 8'h00, 0);
    vecs[15] = mk(32'h0,        8'h00, 0, 0, 8'h00, 0);
    vecs[16] = mk(A_DATA,       8'h00, 0, 0, 8'h00, 0);

    for (int i = 0; i < 17; i++) begin
      set_in(vecs[i].a, vecs[i].d, vecs[i].wr);
      io_buffer_full = vecs[i].full;
      @(negedge clk);
      check($sformatf("vec%0d_ctl", i), {uart_wr, stop_req, cpu_hold, overflow, halted},
            {vecs[i].exp_wr, vecs[i].exp_stop, vecs[i].exp_hold, vecs[i].exp_ovf, vecs[i].exp_halted});
      if (vecs[i].exp_wr)
        check($sformatf("vec%0d_data", i), {24'h0, uart_data}, {24'h0, vecs[i].exp_data});
      step();
    end

    // Backpressure: hold at 7 entries, 8th accepted, 9th dropped.
    do_reset();
    io_buffer_full = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      set_in(A_DATA, 8'(i), 1'b1);
      step();
    end
    set_in(32'h0, 8'h00, 1'b0);
    @(negedge clk);
    check("bp_hold_at6", {31'h0, cpu_hold}, 32'h0);
    step();
    set_in(A_DATA, 8'h07, 1'b1);
    step();
    set_in(32'h0, 8'h00, 1'b0);
    @(negedge clk);
    check("bp_hold_at7", {31'h0, cpu_hold}, 32'h1);
    check("bp_ovf_at7", {31'h0, overflow}, 32'h0);
    step();
    set_in(A_DATA, 8'h08, 1'b1);
    step();
    @(negedge clk);
    check("bp_ovf_at8", {31'h0, overflow}, 32'h0);
    step();
    set_in(A_DATA, 8'h09, 1'b1);
    step();
    set_in(32'h0, 8'h00, 1'b0);
    @(negedge clk);
    check("bp_ovf_at9", {31'h0, overflow}, 32'h1);
    check("bp_no_out_full", {31'h0, uart_wr}, 32'h0);
    step();
    for (int i = 1; i <= 8; i++) exp_q.push_back(8'(i));
    io_buffer_full = 1'b0;
    drain_check("bp", 30);
    set_in(A_DATA, 8'h00, 1'b0);
    @(negedge clk);
    check("bp_empty_hold", {31'h0, cpu_hold}, 32'h0);
    check("bp_ovf_sticky", {31'h0, overflow}, 32'h1);
    step();

    // Ordered stop: byte then stop entry, stop_req with the zero byte.
    do_reset();
    set_in(A_DATA, 8'h55, 1'b1);
    step();
    set_in(A_STOP, 8'hAA, 1'b1);
    step();
    set_in(32'h0, 8'h00, 1'b0);
    @(negedge clk);
    check("stop_c1", {uart_wr, stop_req, cpu_hold, halted}, 4'b1010);
    check("stop_c1_data", {24'h0, uart_data}, 32'h55);
    step();
    @(negedge clk);
    check("stop_c2", {uart_wr, stop_req, cpu_hold, halted}, 4'b0010);
    step();
    @(negedge clk);
    check("stop_c3", {uart_wr, stop_req, cpu_hold, halted}, 4'b1110);
    check("stop_c3_data", {24'h0, uart_data}, 32'h00);
    step();
    @(negedge clk);
    check("stop_c4", {uart_wr, stop_req, cpu_hold, halted}, 4'b0011);
    step();
    set_in(A_DATA, 8'h77, 1'b1);
    step();
    set_in(32'h0, 8'h00, 1'b0);
    drain_check("halted", 10);
    @(negedge clk);
    check("halted_hold", {cpu_hold, halted}, 2'b11);
    step();

    // Read ordering: an I/O read holds the CPU until earlier bytes have left.
    do_reset();
    io_buffer_full = 1'b1;
    set_in(A_DATA, 8'h11, 1'b1);
    step();
    set_in(A_DATA, 8'h22, 1'b1);
    step();
    set_in(A_DATA, 8'h00, 1'b0);
    @(negedge clk);
    check("rd_hold_pending", {31'h0, cpu_hold}, 32'h1);
    step();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    io_buffer_full = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while (cpu_hold && cyc < 20) begin
        @(negedge clk);
        cyc++;
        if (uart_wr) begin
          if (exp_q.size() == 0) check("rd_extra", {24'h0, uart_data}, 32'hFFFF_FFFF);
          else                   check("rd_data", {24'h0, uart_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
    check("rd_hold_released", {31'h0, cpu_hold}, 32'h0);
    check("rd_all_out", exp_q.size(), 0);
    exp_q.delete();
    step();

    // Asynchronous reset in the middle of a drain.
    do_reset();
    io_buffer_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(A_DATA, 8'hC0 + 8'(i), 1'b1);
      step();
    end
    set_in(32'h0, 8'h00, 1'b0);
    io_buffer_full = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (uart_wr) break;
    end
    check("ar_drain_started", {31'h0, uart_wr}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_async_clear", {uart_wr, stop_req, cpu_hold, overflow, halted}, 5'b0);
    check("ar_data_clear", {24'h0, uart_data}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    drain_check("ar_residual", 12);
    set_in(A_DATA, 8'h00, 1'b0);
    @(negedge clk);
    check("ar_empty_hold", {31'h0, cpu_hold}, 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
